// File: rtl/operand_loader_pkg.sv
// operand_loader_pkg: shared states and constants for the operand loader.
package operand_loader_pkg;
  typedef enum logic [2:0] {IDLE, OP1, OP2, CSUM, HOLD} ol_state_t;
  localparam logic [3:0] OL_HDR_TAG = 4'hA;
  localparam logic OL_OP_ADD = 1'b1;
  localparam logic OL_OP_SUB = 1'b0;
endpackage

// File: rtl/operand_loader_csum.sv
// operand_loader_csum: running XOR of header and operand bytes, compared against the trailing checksum byte.
module operand_loader_csum (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic [7:0] i_data,
  output logic       o_match
);
  logic [7:0] r_xor;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_xor <= '0;
    else if (i_clr) r_xor <= i_data;
    else if (i_en) r_xor <= r_xor ^ i_data;
  assign o_match = r_xor == i_data;
endmodule

// File: rtl/operand_loader.sv
// operand_loader: parses header + two big-endian operands from a byte stream into a held add/sub command.
// Define OPERAND_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before the command is presented.
module operand_loader
  import operand_loader_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] operand1,
  output logic [DATA_W-1:0] operand2,
  output logic              op_sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              err
);
  localparam int NB = DATA_W / 8;
  localparam int CW = NB > 1 ? $clog2(NB) : 1;
`ifdef OPERAND_LOADER_CHECKSUM_EN
  localparam ol_state_t OP2_DONE = CSUM;
`else
  localparam ol_state_t OP2_DONE = HOLD;
`endif
  ol_state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [DATA_W-1:0] r_op1, r_op2;
  logic r_op_sel, r_vld, r_err;
  logic w_acc, w_last, w_hdr_ok, w_err;
  assign in_ready = !r_vld;
  assign w_acc = in_valid && in_ready;
  assign w_last = r_cnt == CW'(NB - 1);
  assign w_hdr_ok = in_data[7:4] == OL_HDR_TAG;
  assign operand1 = r_op1;
  assign operand2 = r_op2;
  assign op_sel = r_op_sel;
  assign out_valid = r_vld;
  assign err = r_err;
`ifdef OPERAND_LOADER_CHECKSUM_EN
  logic w_match;
  operand_loader_csum u_csum (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_acc && r_state == IDLE && w_hdr_ok),
    .i_en   (w_acc && (r_state == OP1 || r_state == OP2)),
    .i_data (in_data),
    .o_match(w_match)
  );
`endif
  always_comb begin
    w_next = r_state;
    w_err = 1'b0;
    case (r_state)
      IDLE: begin
        w_next = w_acc && w_hdr_ok ? OP1 : IDLE;
        w_err = w_acc && !w_hdr_ok;
      end
      OP1: w_next = w_acc && w_last ? OP2 : OP1;
      OP2: w_next = w_acc && w_last ? OP2_DONE : OP2;
`ifdef OPERAND_LOADER_CHECKSUM_EN
      CSUM: begin
        w_next = !w_acc ? CSUM : w_match ? HOLD : IDLE;
        w_err = w_acc && !w_match;
      end
`endif
      HOLD: w_next = out_ready ? IDLE : HOLD;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_op1 <= '0;
      r_op2 <= '0;
      r_op_sel <= 1'b0;
      r_vld <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_state <= w_next;
      r_vld <= w_next == HOLD;
      r_err <= w_err;
      if (w_acc && r_state == IDLE && w_hdr_ok) begin
        r_op_sel <= in_data[0];
        r_cnt <= '0;
      end
      if (w_acc && (r_state == OP1 || r_state == OP2))
        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      if (w_acc && r_state == OP1) r_op1 <= (r_op1 << 8) | DATA_W'(in_data);
      if (w_acc && r_state == OP2) r_op2 <= (r_op2 << 8) | DATA_W'(in_data);
    end
  end
endmodule

// File: tb/tb_operand_loader.sv
// tb_operand_loader: directed vectors for operand_loader with hand-computed expectations.
module tb_operand_loader;
  logic clk = 0, rst = 0;
  logic [7:0] in_data = '0;
  logic in_valid = 0, out_ready = 0;
  logic in_ready, op_sel, out_valid, err;
  logic [31:0] operand1, operand2;
  int n_chk = 0, n_fail = 0;
  logic [7:0] f_add [9] = '{8'hA1, 8'h12, 8'h34, 8'h56, 8'h78, 8'h87, 8'h65, 8'h43, 8'h21};
  logic [7:0] f_sub [9] = '{8'hA0, 8'h87, 8'h65, 8'h43, 8'h21, 8'h12, 8'h34, 8'h56, 8'h78};
  logic [7:0] f_rst [9] = '{8'hA0, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h03};
  int hi;

  operand_loader #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .operand1(operand1), .operand2(operand2), .op_sel(op_sel),
    .out_valid(out_valid), .out_ready(out_ready), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [7:0] b);
    in_data = b;
    in_valid = 1;
    tick();
    in_valid = 0;
  endtask

  initial begin
    tick();
    chk("rst_op1", operand1, 0);
    chk("rst_op2", operand2, 0);
    chk("rst_sel", op_sel, 0);
    chk("rst_vld", out_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_rdy", in_ready, 1);
    rst = 1;
    tick();

    // add command, consumer always ready
    out_ready = 1;
    hi = 0;
    for (int i = 0; i < 9; i++) begin
      put(f_add[i]);
      if (i < 8 && out_valid) hi++;
    end
    chk("add_early_vld", hi, 0);
    chk("add_vld", out_valid, 1);
    chk("add_rdy", in_ready, 0);
    chk("add_op1", operand1, 32'h12345678);
    chk("add_op2", operand2, 32'h87654321);
    chk("add_sel", op_sel, 1);
    tick();
    chk("add_vld_fall", out_valid, 0);
    chk("add_rdy_back", in_ready, 1);

    // subtract with backpressure; junk bytes during hold must be refused
    out_ready = 0;
    for (int i = 0; i < 9; i++) put(f_sub[i]);
    chk("sub_vld", out_valid, 1);
    chk("sub_sel", op_sel, 0);
    in_data = 8'hFF;
    in_valid = 1;
    hi = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (!out_valid || in_ready || operand1 !== 32'h87654321 || operand2 !== 32'h12345678 || op_sel || err) hi++;
    end
    chk("sub_hold_stable", hi, 0);
    in_valid = 0;
    out_ready = 1;
    tick();
    chk("sub_vld_fall", out_valid, 0);
    chk("sub_rdy_back", in_ready, 1);
    chk("sub_op1_kept", operand1, 32'h87654321);
    tick();
    chk("sub_no_err", err, 0);

    // bad header, then a gapped all-zero add command
    put(8'h31);
    chk("bad_err", err, 1);
    chk("bad_vld", out_valid, 0);
    tick();
    chk("bad_err_pulse", err, 0);
    hi = 0;
    for (int i = 0; i < 9; i++) begin
      put(i == 0 ? 8'hA1 : 8'h00);
      if (err) hi++;
      if (i < 8) tick();
    end
    chk("gap_no_err", hi, 0);
    chk("gap_vld", out_valid, 1);
    chk("gap_op1", operand1, 0);
    chk("gap_op2", operand2, 0);
    chk("gap_sel", op_sel, 1);
    tick();

    // reset mid-command after five bytes
    for (int i = 0; i < 5; i++) put(f_add[i]);
    chk("pre_rst_op1", operand1, 32'h12345678);
    #2 rst = 0;
    #1;
    chk("mid_rst_op1", operand1, 0);
    chk("mid_rst_sel", op_sel, 0);
    chk("mid_rst_vld", out_valid, 0);
    chk("mid_rst_rdy", in_ready, 1);
    tick();
    rst = 1;
    hi = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid) hi++;
    end
    chk("rst_no_vld", hi, 0);
    for (int i = 0; i < 9; i++) put(f_rst[i]);
    chk("new_vld", out_valid, 1);
    chk("new_op1", operand1, 32'h5);
    chk("new_op2", operand2, 32'h3);
    chk("new_sel", op_sel, 0);
    tick();

`ifdef OPERAND_LOADER_CHECKSUM_EN
    for (int i = 0; i < 9; i++) put(f_add[i]);
    chk("cs_wait_vld", out_valid, 0);
    put(8'h29);
    chk("cs_ok_vld", out_valid, 1);
    chk("cs_ok_err", err, 0);
    tick();
    for (int i = 0; i < 9; i++) put(f_add[i]);
    put(8'h28);
    chk("cs_bad_err", err, 1);
    chk("cs_bad_vld", out_valid, 0);
    tick();
    chk("cs_bad_vld2", out_valid, 0);
    chk("cs_bad_err_pulse", err, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
